// File: rtl/alu_arbiter.sv
// alu_arbiter: lets two requesters take turns on one combinational ALU.
//
// A request is accepted only when the block is idle. The accepted opcode and
// operands are registered onto the ALU inputs. One cycle later the ALU result
// and flags are captured into the owner's response registers, and they are
// held until the owner takes them. When both requesters are valid, a
// round-robin pointer picks the winner.
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   reqN_valid/ready              request handshake (N = 0, 1)
//   reqN_op, reqN_a, reqN_b       request opcode and operands
//   rspN_valid/ready              response handshake
//   rspN_f, rspN_zf, rspN_of      captured ALU result and flags
//   alu_op, alu_a, alu_b          registered ALU inputs
//   alu_f, alu_zf, alu_of         ALU result and flags
module alu_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_f,
    output logic              rsp0_zf,
    output logic              rsp0_of,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_f,
    output logic              rsp1_zf,
    output logic              rsp1_of,

    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_f,
    input  logic              alu_zf,
    input  logic              alu_of
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic              ptr_q;    // requester favoured on a tie
    logic              owner_q;  // requester whose operation is in flight
    logic [OP_W-1:0]   alu_op_q;
    logic [DATA_W-1:0] alu_a_q, alu_b_q;
    logic              rsp0_valid_q, rsp1_valid_q;
    logic [DATA_W-1:0] rsp0_f_q, rsp1_f_q;
    logic              rsp0_zf_q, rsp0_of_q, rsp1_zf_q, rsp1_of_q;

    logic winner;
    logic grant;
    logic rsp_done;

    always_comb begin
        winner     = 1'b0;
        grant      = 1'b0;
        rsp_done   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        state_d    = state_q;

        // A lone valid requester wins; a tie goes to the pointer.
        winner = (req0_valid && req1_valid) ? ptr_q : req1_valid;
        grant  = (state_q == StIdle) && (req0_valid || req1_valid);

        req0_ready = grant && !winner;
        req1_ready = grant && winner;

        rsp_done = owner_q ? (rsp1_valid_q && rsp1_ready) : (rsp0_valid_q && rsp0_ready);

        unique case (state_q)
            StIdle:  if (grant) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ptr_q        <= 1'b0;
            owner_q      <= 1'b0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_f_q     <= '0;
            rsp1_f_q     <= '0;
            rsp0_zf_q    <= 1'b0;
            rsp0_of_q    <= 1'b0;
            rsp1_zf_q    <= 1'b0;
            rsp1_of_q    <= 1'b0;
        end else begin
            state_q <= state_d;

            if (grant) begin
                alu_op_q <= winner ? req1_op : req0_op;
                alu_a_q  <= winner ? req1_a : req0_a;
                alu_b_q  <= winner ? req1_b : req0_b;
                owner_q  <= winner;
                ptr_q    <= ~winner;
            end

            if (state_q == StExec) begin
                if (owner_q) begin
                    rsp1_f_q     <= alu_f;
                    rsp1_zf_q    <= alu_zf;
                    rsp1_of_q    <= alu_of;
                    rsp1_valid_q <= 1'b1;
                end else begin
                    rsp0_f_q     <= alu_f;
                    rsp0_zf_q    <= alu_zf;
                    rsp0_of_q    <= alu_of;
                    rsp0_valid_q <= 1'b1;
                end
            end

            if ((state_q == StResp) && rsp_done) begin
                if (owner_q) rsp1_valid_q <= 1'b0;
                else         rsp0_valid_q <= 1'b0;
            end
        end
    end

    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_f     = rsp0_f_q;
    assign rsp0_zf    = rsp0_zf_q;
    assign rsp0_of    = rsp0_of_q;
    assign rsp1_f     = rsp1_f_q;
    assign rsp1_zf    = rsp1_zf_q;
    assign rsp1_of    = rsp1_of_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: an external ALU model is attached, and a response
// scoreboard per requester is filled at each request handshake.
module tb_alu_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;

    typedef struct packed {
        logic [DATA_W-1:0] f;
        logic              zf;
        logic              of;
    } res_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [OP_W-1:0]   req0_op, req1_op;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic              rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [DATA_W-1:0] rsp0_f, rsp1_f;
    logic              rsp0_zf, rsp0_of, rsp1_zf, rsp1_of;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_a, alu_b, alu_f;
    logic              alu_zf, alu_of;
    res_t              alu_r;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    res_t exp0_q[$];
    res_t exp1_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_f     (rsp0_f),
        .rsp0_zf    (rsp0_zf),
        .rsp0_of    (rsp0_of),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_f     (rsp1_f),
        .rsp1_zf    (rsp1_zf),
        .rsp1_of    (rsp1_of),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_f      (alu_f),
        .alu_zf     (alu_zf),
        .alu_of     (alu_of)
    );

    // Reference ALU: 100 = add, 101 = sub, signed overflow on both.
    function automatic res_t alu_model(input logic [OP_W-1:0] op,
                                       input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
        res_t r;
        r.of = 1'b0;
        case (op)
            3'd0: r.f = a & b;
            3'd1: r.f = a | b;
            3'd2: r.f = a ^ b;
            3'd3: r.f = ~(a | b);
            3'd4: begin
                r.f  = a + b;
                r.of = (a[DATA_W-1] == b[DATA_W-1]) && (r.f[DATA_W-1] != a[DATA_W-1]);
            end
            3'd5: begin
                r.f  = a - b;
                r.of = (a[DATA_W-1] != b[DATA_W-1]) && (r.f[DATA_W-1] != a[DATA_W-1]);
            end
            3'd6: r.f = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: r.f = b;
        endcase
        r.zf = (r.f == '0);
        return r;
    endfunction

    always_comb begin
        alu_r  = alu_model(alu_op, alu_a, alu_b);
        alu_f  = alu_r.f;
        alu_zf = alu_r.zf;
        alu_of = alu_r.of;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int id, input int max_cyc);
        logic found;
        found = 1'b0;
        for (int i = 0; i < max_cyc && !found; i++) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) found = 1'b1;
        end
        if (!found) check_eq(id == 0 ? "req0_grant_timeout" : "req1_grant_timeout", 0, 1);
    endtask

    task automatic wait_rsp(input int id, input int max_cyc);
        logic found;
        found = 1'b0;
        for (int i = 0; i < max_cyc && !found; i++) begin
            @(negedge clk);
            if ((id == 0) ? rsp0_valid : rsp1_valid) found = 1'b1;
        end
        if (!found) check_eq(id == 0 ? "rsp0_timeout" : "rsp1_timeout", 0, 1);
    endtask

    // Scoreboard: push at request handshake, pop at response handshake.
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            exp0_q.delete();
            exp1_q.delete();
        end else begin
            check_eq("ready_excl", {63'd0, req0_ready & req1_ready}, 0);
            check_eq("rsp_valid_excl", {63'd0, rsp0_valid & rsp1_valid}, 0);
            if (req0_valid && req0_ready) exp0_q.push_back(alu_model(req0_op, req0_a, req0_b));
            if (req1_valid && req1_ready) exp1_q.push_back(alu_model(req1_op, req1_a, req1_b));
            if (rsp0_valid && rsp0_ready) begin
                if (exp0_q.size() == 0) check_eq("rsp0_unexpected", 1, 0);
                else begin
                    e = exp0_q.pop_front();
                    check_eq("sb_rsp0", {rsp0_f, rsp0_zf, rsp0_of}, {e.f, e.zf, e.of});
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                if (exp1_q.size() == 0) check_eq("rsp1_unexpected", 1, 0);
                else begin
                    e = exp1_q.pop_front();
                    check_eq("sb_rsp1", {rsp1_f, rsp1_zf, rsp1_of}, {e.f, e.zf, e.of});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int gid[$];
        int gcyc[$];
        int n0, n1;
        logic h0, h1;

        rst = 1'b1;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        step(); step(); step();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_req_ready", {req0_ready, req1_ready}, 0);
        check_eq("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        check_eq("rst_alu_op", alu_op, 0);
        check_eq("rst_alu_a", alu_a, 0);
        check_eq("rst_alu_b", alu_b, 0);
        check_eq("rst_rsp0_f", rsp0_f, 0);

        // Single request: 5 + 7
        step();
        req0_valid = 1'b1; req0_op = 3'd4; req0_a = 32'd5; req0_b = 32'd7;
        @(negedge clk);
        check_eq("t1_req0_ready", req0_ready, 1);
        check_eq("t1_req1_ready", req1_ready, 0);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        check_eq("t1_alu_op", alu_op, 4);
        check_eq("t1_alu_a", alu_a, 5);
        check_eq("t1_alu_b", alu_b, 7);
        check_eq("t1_rsp0_early", rsp0_valid, 0);
        @(negedge clk);
        check_eq("t1_rsp0_valid", rsp0_valid, 1);
        check_eq("t1_rsp0_f", rsp0_f, 12);
        check_eq("t1_rsp0_flags", {rsp0_zf, rsp0_of}, 0);
        check_eq("t1_rsp1_valid", rsp1_valid, 0);
        step();
        @(negedge clk);
        check_eq("t1_rsp0_cleared", rsp0_valid, 0);

        // Both valid continuously after reset: 0,1,0,1 three cycles apart
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd5; req0_a = 32'd10;  req0_b = 32'd20;
        req1_valid = 1'b1; req1_op = 3'd4; req1_a = 32'd100; req1_b = 32'd1;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 40 && (n0 + n1) < 4; i++) begin
            @(negedge clk);
            h0 = req0_valid && req0_ready;
            h1 = req1_valid && req1_ready;
            if (h0) begin gid.push_back(0); gcyc.push_back(cyc); n0++; end
            if (h1) begin gid.push_back(1); gcyc.push_back(cyc); n1++; end
            step();
            if (h0 && n0 == 2) req0_valid = 1'b0;
            if (h1 && n1 == 2) req1_valid = 1'b0;
        end
        check_eq("t2_grant_count", gid.size(), 4);
        if (gid.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check_eq("t2_grant_order", gid[i], i % 2);
                if (i > 0) check_eq("t2_grant_spacing", gcyc[i] - gcyc[i-1], 3);
            end
        end
        wait_rsp(1, 10);
        step();

        // Overflow and zero flag on requester 1
        req1_valid = 1'b1; req1_op = 3'd4; req1_a = 32'h7FFF_FFFF; req1_b = 32'd1;
        wait_grant(1, 5);
        step();
        req1_valid = 1'b0;
        wait_rsp(1, 5);
        check_eq("t3_ovf_f", rsp1_f, 32'h8000_0000);
        check_eq("t3_ovf_of", rsp1_of, 1);
        check_eq("t3_ovf_zf", rsp1_zf, 0);
        step();
        req1_valid = 1'b1; req1_op = 3'd5; req1_a = 32'h1234; req1_b = 32'h1234;
        wait_grant(1, 5);
        step();
        req1_valid = 1'b0;
        wait_rsp(1, 5);
        check_eq("t3_zero_f", rsp1_f, 0);
        check_eq("t3_zero_zf", rsp1_zf, 1);
        check_eq("t3_zero_of", rsp1_of, 0);
        step();

        // Response back-pressure for 4 cycles, req1 waiting throughout
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd4; req0_a = 32'd1; req0_b = 32'd2;
        wait_grant(0, 5);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 3'd4; req1_a = 32'd3; req1_b = 32'd4;
        @(negedge clk);
        check_eq("t4_exec_req1_ready", req1_ready, 0);
        @(negedge clk);
        check_eq("t4_rsp0_valid", rsp0_valid, 1);
        check_eq("t4_rsp0_f", rsp0_f, 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t4_hold_valid", rsp0_valid, 1);
            check_eq("t4_hold_payload", {rsp0_f, rsp0_zf, rsp0_of}, {32'd3, 1'b0, 1'b0});
            check_eq("t4_hold_ready", {req0_ready, req1_ready}, 0);
        end
        step();
        rsp0_ready = 1'b1;
        @(negedge clk);
        check_eq("t4_done_valid", rsp0_valid, 1);
        check_eq("t4_done_no_grant", req1_ready, 0);
        step();
        @(negedge clk);
        check_eq("t4_idle_rsp0", rsp0_valid, 0);
        check_eq("t4_idle_grant1", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        wait_rsp(1, 5);
        check_eq("t4_rsp1_f", rsp1_f, 7);
        step();

        // Reset during EXEC drops the operation and re-arms the pointer
        req0_valid = 1'b1; req0_op = 3'd4; req0_a = 32'd2; req0_b = 32'd3;
        wait_grant(0, 5);
        step();
        req0_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check_eq("t5_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        check_eq("t5_rsp0_payload", {rsp0_f, rsp0_zf, rsp0_of}, 0);
        check_eq("t5_rsp1_payload", {rsp1_f, rsp1_zf, rsp1_of}, 0);
        check_eq("t5_alu_in", {alu_op, alu_a, alu_b}, 0);
        check_eq("t5_req_ready", {req0_ready, req1_ready}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t5_no_rsp", rsp0_valid, 0);
        end
        step();
        req0_valid = 1'b1; req0_op = 3'd4; req0_a = 32'd10; req0_b = 32'd11;
        req1_valid = 1'b1; req1_op = 3'd5; req1_a = 32'd50; req1_b = 32'd8;
        @(negedge clk);
        check_eq("t5_first_grant0", req0_ready, 1);
        check_eq("t5_first_grant1", req1_ready, 0);
        step();
        req0_valid = 1'b0;
        wait_grant(1, 6);
        step();
        req1_valid = 1'b0;
        wait_rsp(1, 5);
        check_eq("t5_rsp1_f", rsp1_f, 42);
        step();

        // Payload change while not ready: the value at the handshake is used
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 3'd4; req1_a = 32'd1; req1_b = 32'd1;
        wait_grant(1, 5);
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd4; req0_a = 32'd3; req0_b = 32'd100;
        @(negedge clk);
        check_eq("t6_exec_ready", req0_ready, 0);
        step();
        req0_a = 32'd9;
        @(negedge clk);
        check_eq("t6_resp_ready", req0_ready, 0);
        step();
        rsp1_ready = 1'b1;
        @(negedge clk);
        check_eq("t6_done_ready", req0_ready, 0);
        step();
        @(negedge clk);
        check_eq("t6_grant", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        check_eq("t6_alu_a", alu_a, 9);
        check_eq("t6_alu_b", alu_b, 100);
        wait_rsp(0, 5);
        check_eq("t6_rsp0_f", rsp0_f, 109);
        step();

        for (int i = 0; i < 4; i++) step();
        check_eq("sb0_drained", exp0_q.size(), 0);
        check_eq("sb1_drained", exp1_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
